// File: rtl/vmask_scan.sv
// rtl/vmask_scan.sv - two-stage chunked mask scan for vfirst.m / vmsbf.m / vmsif.m / vmsof.m
// Optional popcount (vcpop.m on in_op=100) built when VMASK_SCAN_VCPOP_EN is defined.
module vmask_scan #(
  parameter int REQ_DATA_WIDTH  = 64,
  parameter int RESP_DATA_WIDTH = 64,
  parameter int IDX_BITS        = 10,
  parameter int CHUNK_WIDTH     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       in_first,
  input  logic                       in_last,
  input  logic [2:0]                 in_op,
  input  logic [REQ_DATA_WIDTH-1:0]  in_m0,
  input  logic [REQ_DATA_WIDTH-1:0]  in_en,
  input  logic [IDX_BITS-1:0]        in_idx,
  output logic                       out_valid,
  output logic                       out_last,
  output logic [RESP_DATA_WIDTH-1:0] out_vec,
  output logic                       out_found
);

  localparam int NCHUNK = REQ_DATA_WIDTH / CHUNK_WIDTH;
  localparam int LBITS  = $clog2(CHUNK_WIDTH);
  localparam int LOWW   = $clog2(REQ_DATA_WIDTH);

  typedef enum logic [2:0] {
    K_VFIRST = 3'd0,
    K_VMSBF  = 3'd1,
    K_VMSIF  = 3'd2,
    K_VMSOF  = 3'd3,
    K_VCPOP  = 3'd4
  } kind_t;

  // ---------------- stage A: per-chunk priority encode ----------------
  logic [REQ_DATA_WIDTH-1:0] eff;
  logic [NCHUNK-1:0]         c_any;
  logic [LBITS-1:0]          c_low [NCHUNK];
  kind_t                     in_kind;

  assign eff = in_m0 & in_en;

  always_comb begin
    for (int c = 0; c < NCHUNK; c++) begin
      c_any[c] = |eff[c*CHUNK_WIDTH +: CHUNK_WIDTH];
      c_low[c] = '0;
      for (int j = CHUNK_WIDTH - 1; j >= 0; j--) begin
        if (eff[c*CHUNK_WIDTH + j]) c_low[c] = LBITS'(j);
      end
    end
  end

  // Reserved codes, and 100 when popcount is not built, fall back to vfirst.
  always_comb begin
    in_kind = K_VFIRST;
    case (in_op)
      3'b001:  in_kind = K_VMSBF;
      3'b010:  in_kind = K_VMSIF;
      3'b011:  in_kind = K_VMSOF;
`ifdef VMASK_SCAN_VCPOP_EN
      3'b100:  in_kind = K_VCPOP;
`endif
      default: in_kind = K_VFIRST;
    endcase
  end

  logic                      a_valid;
  logic                      a_first;
  logic                      a_last;
  kind_t                     a_kind;
  logic [IDX_BITS-1:0]       a_idx;
  logic [REQ_DATA_WIDTH-1:0] a_en;
  logic [NCHUNK-1:0]         a_any;
  logic [LBITS-1:0]          a_low [NCHUNK];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid <= 1'b0;
      a_first <= 1'b0;
      a_last  <= 1'b0;
      a_kind  <= K_VFIRST;
      a_idx   <= '0;
      a_en    <= '0;
      a_any   <= '0;
      for (int c = 0; c < NCHUNK; c++) a_low[c] <= '0;
    end else begin
      a_valid <= in_valid;
      if (in_valid) begin
        a_first <= in_first;
        a_last  <= in_last;
        a_kind  <= in_kind;
        a_idx   <= in_idx;
        a_en    <= in_en;
        a_any   <= c_any;
        for (int c = 0; c < NCHUNK; c++) a_low[c] <= c_low[c];
      end
    end
  end

`ifdef VMASK_SCAN_VCPOP_EN
  localparam int PW   = LBITS + 1;
  localparam int CNTW = IDX_BITS + 1;

  logic [PW-1:0]   c_pop [NCHUNK];
  logic [PW-1:0]   a_pop [NCHUNK];
  logic [CNTW-1:0] count_r;
  logic [CNTW-1:0] cnt_sum;
  logic [CNTW-1:0] cnt_now;

  always_comb begin
    for (int c = 0; c < NCHUNK; c++) begin
      c_pop[c] = '0;
      for (int j = 0; j < CHUNK_WIDTH; j++) c_pop[c] = c_pop[c] + PW'(eff[c*CHUNK_WIDTH + j]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCHUNK; c++) a_pop[c] <= '0;
    end else if (in_valid) begin
      for (int c = 0; c < NCHUNK; c++) a_pop[c] <= c_pop[c];
    end
  end

  always_comb begin
    cnt_sum = '0;
    for (int c = 0; c < NCHUNK; c++) cnt_sum = cnt_sum + CNTW'(a_pop[c]);
    cnt_now = (a_first ? '0 : count_r) + cnt_sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 count_r <= '0;
    else if (a_valid && a_kind == K_VCPOP)   count_r <= cnt_now;
  end
`endif

  // ---------------- stage B: combine chunks, apply cross-beat state ----------------
  logic                       found_r;
  logic [IDX_BITS-1:0]        cap_r;
  logic                       any;
  logic [LOWW-1:0]            lowest;
  logic                       prev;
  logic                       hit;
  logic [IDX_BITS-1:0]        cap_now;
  logic [REQ_DATA_WIDTH-1:0]  mask_beat;
  logic [RESP_DATA_WIDTH-1:0] res_vec;
  logic                       res_found;
  logic                       res_valid;

  always_comb begin
    any    = |a_any;
    lowest = '0;
    for (int c = NCHUNK - 1; c >= 0; c--) begin
      if (a_any[c]) lowest = LOWW'(c*CHUNK_WIDTH) + LOWW'(a_low[c]);
    end
    prev    = a_first ? 1'b0 : found_r;
    hit     = any & ~prev;
    cap_now = hit ? (a_idx + IDX_BITS'(lowest)) : cap_r;
  end

  always_comb begin
    mask_beat = '0;
    if (!prev && !any) begin
      mask_beat = (a_kind == K_VMSOF) ? '0 : '1;
    end else if (!prev) begin
      for (int i = 0; i < REQ_DATA_WIDTH; i++) begin
        case (a_kind)
          K_VMSBF: mask_beat[i] = LOWW'(i) <  lowest;
          K_VMSIF: mask_beat[i] = LOWW'(i) <= lowest;
          default: mask_beat[i] = LOWW'(i) == lowest;
        endcase
      end
    end
    mask_beat = mask_beat & a_en;
  end

  always_comb begin
    res_vec   = '0;
    res_found = prev | any;
    res_valid = a_valid & a_last;
    case (a_kind)
      K_VMSBF, K_VMSIF, K_VMSOF: begin
        res_vec   = RESP_DATA_WIDTH'(mask_beat);
        res_valid = a_valid;
      end
`ifdef VMASK_SCAN_VCPOP_EN
      K_VCPOP: begin
        res_vec   = RESP_DATA_WIDTH'(cnt_now);
        res_found = cnt_now != '0;
      end
`endif
      default: res_vec = (prev | any) ? RESP_DATA_WIDTH'(cap_now) : '1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      found_r   <= 1'b0;
      cap_r     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_vec   <= '0;
      out_found <= 1'b0;
    end else begin
      if (a_valid) begin
        found_r <= prev | any;
        if (hit) cap_r <= cap_now;
      end
      out_valid <= res_valid;
      out_last  <= res_valid & a_last;
      out_vec   <= res_valid ? res_vec : '0;
      out_found <= res_valid & res_found;
    end
  end

endmodule

// File: tb/tb_vmask_scan.sv
// tb/tb_vmask_scan.sv - directed scoreboard bench for vmask_scan
module tb_vmask_scan;

  localparam logic [2:0] OP_VFIRST = 3'b000;
  localparam logic [2:0] OP_VMSBF  = 3'b001;
  localparam logic [2:0] OP_VMSIF  = 3'b010;
  localparam logic [2:0] OP_VMSOF  = 3'b011;
  localparam logic [2:0] OP_VCPOP  = 3'b100;
  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_first = 1'b0;
  logic        in_last = 1'b0;
  logic [2:0]  in_op = 3'b000;
  logic [63:0] in_m0 = '0;
  logic [63:0] in_en = '0;
  logic [9:0]  in_idx = '0;
  logic        out_valid;
  logic        out_last;
  logic [63:0] out_vec;
  logic        out_found;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        last;
    logic [63:0] vec;
    logic        found;
  } exp_t;

  exp_t q[$];
  exp_t e;

  vmask_scan dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .in_op(in_op), .in_m0(in_m0), .in_en(in_en), .in_idx(in_idx),
    .out_valid(out_valid), .out_last(out_last), .out_vec(out_vec), .out_found(out_found)
  );

  always #5 clk = ~clk;

  task automatic beat(input logic [2:0] op, input logic [63:0] m0, input logic [63:0] en,
                      input logic [9:0] idx, input logic first, input logic last);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_m0 = m0; in_en = en;
    in_idx = idx; in_first = first; in_last = last;
  endtask

  task automatic bubble();
    @(negedge clk);
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; in_m0 = '0;
  endtask

  task automatic expect_out(input logic last, input logic [63:0] vec, input logic found);
    exp_t x;
    x.last = last; x.vec = vec; x.found = found;
    q.push_back(x);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL spurious_out observed=%h expected=none", out_vec);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        checks++;
        assert (out_vec === e.vec) else begin
          errors++; $error("FAIL out_vec observed=%h expected=%h", out_vec, e.vec);
        end
        checks++;
        assert (out_found === e.found) else begin
          errors++; $error("FAIL out_found observed=%b expected=%b", out_found, e.found);
        end
        checks++;
        assert (out_last === e.last) else begin
          errors++; $error("FAIL out_last observed=%b expected=%b", out_last, e.last);
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", {63'b0, out_valid}, 64'd0);
    chk("reset_vec", out_vec, 64'd0);
    chk("reset_found", {63'b0, out_found}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // single-beat vfirst
    beat(OP_VFIRST, 64'h0100_0000, ALL1, 10'd0, 1'b1, 1'b1); expect_out(1'b1, 64'd24, 1'b1);
    // 3 beats with a bubble
    beat(OP_VFIRST, 64'h0, ALL1, 10'd0, 1'b1, 1'b0);
    beat(OP_VFIRST, 64'h8, ALL1, 10'd64, 1'b0, 1'b0);
    bubble();
    beat(OP_VFIRST, 64'h1, ALL1, 10'd128, 1'b0, 1'b1); expect_out(1'b1, 64'd67, 1'b1);
    // nothing found over 2 beats
    beat(OP_VFIRST, 64'h0, ALL1, 10'd0, 1'b1, 1'b0);
    beat(OP_VFIRST, 64'h0, ALL1, 10'd64, 1'b0, 1'b1); expect_out(1'b1, ALL1, 1'b0);
    // back-to-back mask ops
    beat(OP_VMSBF, 64'h10, ALL1, 10'd0, 1'b1, 1'b1); expect_out(1'b1, 64'hF, 1'b1);
    beat(OP_VMSIF, 64'h10, ALL1, 10'd0, 1'b1, 1'b1); expect_out(1'b1, 64'h1F, 1'b1);
    beat(OP_VMSOF, 64'h10, ALL1, 10'd0, 1'b1, 1'b1); expect_out(1'b1, 64'h10, 1'b1);
    // 2-beat vmsif
    beat(OP_VMSIF, 64'h0, ALL1, 10'd0, 1'b1, 1'b0); expect_out(1'b0, ALL1, 1'b0);
    beat(OP_VMSIF, 64'h4, ALL1, 10'd64, 1'b0, 1'b1); expect_out(1'b1, 64'h7, 1'b1);
    // enable gating
    beat(OP_VFIRST, 64'h3, ~64'h1, 10'd0, 1'b1, 1'b1); expect_out(1'b1, 64'd1, 1'b1);
    beat(OP_VMSOF, 64'h3, ~64'h1, 10'd0, 1'b1, 1'b1); expect_out(1'b1, 64'h2, 1'b1);
    // cross-chunk positions and found carried into a later beat
    beat(OP_VMSBF, 64'h0000_0100_0000_0000, ALL1, 10'd0, 1'b1, 1'b1);
    expect_out(1'b1, 64'h0000_00FF_FFFF_FFFF, 1'b1);
    beat(OP_VFIRST, 64'h8000_0000_0000_0000, ALL1, 10'd256, 1'b1, 1'b1); expect_out(1'b1, 64'd319, 1'b1);
    beat(OP_VMSOF, 64'h8000_0000_0000_0000, ALL1, 10'd0, 1'b1, 1'b0);
    expect_out(1'b0, 64'h8000_0000_0000_0000, 1'b1);
    beat(OP_VMSOF, 64'h1, ALL1, 10'd64, 1'b0, 1'b1); expect_out(1'b1, 64'h0, 1'b1);
    // in_first abandons an unfinished operation
    beat(OP_VFIRST, 64'h1, ALL1, 10'd0, 1'b1, 1'b0);
    beat(OP_VFIRST, 64'h0, ALL1, 10'd0, 1'b1, 1'b1); expect_out(1'b1, ALL1, 1'b0);
    // reserved op decodes as vfirst
    beat(3'b111, 64'h200, ALL1, 10'd0, 1'b1, 1'b1); expect_out(1'b1, 64'd9, 1'b1);
`ifdef VMASK_SCAN_VCPOP_EN
    beat(OP_VCPOP, 64'hFF, ALL1, 10'd0, 1'b1, 1'b0);
    beat(OP_VCPOP, 64'h3, ALL1, 10'd64, 1'b0, 1'b1); expect_out(1'b1, 64'd10, 1'b1);
`else
    beat(OP_VCPOP, 64'h80, ALL1, 10'd0, 1'b1, 1'b1); expect_out(1'b1, 64'd7, 1'b1);
`endif
    repeat (4) bubble();
    chk("drain_a", 64'(q.size()), 64'd0);

    // async reset while a result is on the output and a vfirst (bit 5 found) is in flight
    beat(OP_VMSBF, 64'h10, ALL1, 10'd0, 1'b1, 1'b1);
    beat(OP_VFIRST, 64'h20, ALL1, 10'd0, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    chk("pre_reset_valid", {63'b0, out_valid}, 64'd1);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("mid_reset_valid", {63'b0, out_valid}, 64'd0);
    chk("mid_reset_vec", out_vec, 64'd0);
    chk("mid_reset_found", {63'b0, out_found}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    beat(OP_VFIRST, 64'h4, ALL1, 10'd0, 1'b1, 1'b1); expect_out(1'b1, 64'd2, 1'b1);
    repeat (5) bubble();
    chk("drain_b", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
